// File: rtl/serdes_pkg.sv
// Shared PAM4 receive definitions: Gray symbol map, default slicer thresholds,
// receive FSM states and a 2-bit popcount helper.
package serdes_pkg;

   localparam logic [1:0] SYM_M3 = 2'b00;
   localparam logic [1:0] SYM_M1 = 2'b01;
   localparam logic [1:0] SYM_P1 = 2'b11;
   localparam logic [1:0] SYM_P3 = 2'b10;

   localparam int THR_LO_DEF  = -64;
   localparam int THR_MID_DEF = 0;
   localparam int THR_HI_DEF  = 64;

   typedef enum logic [1:0] {IDLE, RUN, DONE} rx_state_t;

   function automatic logic [1:0] popcount2(input logic [1:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]};
   endfunction

endpackage

// File: rtl/ref_sym_fifo.sv
// Synchronous reference-symbol FIFO with first-word-fall-through read and a
// synchronous clear; a push while full only succeeds if a pop happens alongside.
module ref_sym_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: occupancy is tracked by cnt_q.
   always_ff @(posedge clk) begin
      if (do_push && !clr) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/rx_pam4_slicer_ber.sv
// PAM4 receive slicer with windowed symbol/bit error counting against a buffered
// reference stream. Define RX_SLICER_HIST_EN to add per-level decision histograms.
module rx_pam4_slicer_ber
   import serdes_pkg::*;
#(
   parameter int          THR_LO     = THR_LO_DEF,
   parameter int          THR_MID    = THR_MID_DEF,
   parameter int          THR_HI     = THR_HI_DEF,
   parameter int unsigned NUM_SYMS   = 1024,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic [7:0]       sample_in,
   input  logic             sample_in_valid,
   input  logic [1:0]       ref_sym,
   input  logic             ref_sym_valid,
   output logic [1:0]       sym_out,
   output logic             sym_out_valid,
   output logic [CNT_W-1:0] sym_cnt,
   output logic [CNT_W-1:0] sym_err_cnt,
   output logic [CNT_W-1:0] bit_err_cnt,
   output logic             done,
   output logic             ovf,
   output logic             unf
`ifdef RX_SLICER_HIST_EN
   ,
   output logic [4*16-1:0]  hist_cnt
`endif
);

   localparam logic signed [7:0] ThrLo  = 8'(THR_LO);
   localparam logic signed [7:0] ThrMid = 8'(THR_MID);
   localparam logic signed [7:0] ThrHi  = 8'(THR_HI);

   rx_state_t        state_q, state_d;
   logic [1:0]       sym_q, sym_d;
   logic             sym_vld_q;
   logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
   logic [CNT_W-1:0] sym_err_q, sym_err_d;
   logic [CNT_W-1:0] bit_err_q, bit_err_d;
   logic             done_q, done_d, ovf_q, ovf_d, unf_q, unf_d;

   logic signed [7:0] sample_s;
   logic [1:0]        slice_sym, diff;
   logic [CNT_W:0]    bit_sum;
   logic              fifo_clr, fifo_full, fifo_empty, reached, cmp;
   logic [1:0]        fifo_dout;

   assign sample_s = sample_in;

   always_comb begin
      slice_sym = SYM_P3;
      if (sample_s < ThrLo)       slice_sym = SYM_M3;
      else if (sample_s < ThrMid) slice_sym = SYM_M1;
      else if (sample_s < ThrHi)  slice_sym = SYM_P1;
   end

   ref_sym_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (2)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .clr   (fifo_clr),
      .push  (ref_sym_valid),
      .pop   (sample_in_valid),
      .din   (ref_sym),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign reached = (64'(sym_cnt_q) >= 64'(NUM_SYMS));
   assign cmp     = (state_q == RUN) && sample_in_valid && !fifo_empty && !reached;
   assign diff    = slice_sym ^ fifo_dout;
   assign bit_sum = {1'b0, bit_err_q} + {{(CNT_W-1){1'b0}}, popcount2(diff)};

   always_comb begin
      state_d   = state_q;
      sym_d     = sample_in_valid ? slice_sym : sym_q;
      sym_cnt_d = sym_cnt_q;
      sym_err_d = sym_err_q;
      bit_err_d = bit_err_q;
      done_d    = done_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      fifo_clr  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (en) begin
               state_d   = RUN;
               sym_cnt_d = '0;
               sym_err_d = '0;
               bit_err_d = '0;
               done_d    = 1'b0;
               ovf_d     = 1'b0;
               unf_d     = 1'b0;
               fifo_clr  = 1'b1;
            end
         end
         RUN: begin
            if (!en) begin
               state_d = IDLE;
            end else if (reached) begin
               state_d = DONE;
               done_d  = 1'b1;
            end
            if (cmp) begin
               if (sym_cnt_q != '1) sym_cnt_d = sym_cnt_q + 1'b1;
               if (diff != 2'b00 && sym_err_q != '1) sym_err_d = sym_err_q + 1'b1;
               bit_err_d = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
            end
            // Push dropped only when full and nothing is popped this cycle.
            if (ref_sym_valid && fifo_full && !sample_in_valid) ovf_d = 1'b1;
            if (sample_in_valid && fifo_empty) unf_d = 1'b1;
         end
         DONE: begin
            if (!en) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         sym_q     <= 2'b00;
         sym_vld_q <= 1'b0;
         sym_cnt_q <= '0;
         sym_err_q <= '0;
         bit_err_q <= '0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sym_q     <= sym_d;
         sym_vld_q <= sample_in_valid;
         sym_cnt_q <= sym_cnt_d;
         sym_err_q <= sym_err_d;
         bit_err_q <= bit_err_d;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   assign sym_out       = sym_q;
   assign sym_out_valid = sym_vld_q;
   assign sym_cnt       = sym_cnt_q;
   assign sym_err_cnt   = sym_err_q;
   assign bit_err_cnt   = bit_err_q;
   assign done          = done_q;
   assign ovf           = ovf_q;
   assign unf           = unf_q;

`ifdef RX_SLICER_HIST_EN
   logic [15:0] hist_q [4];
   logic [15:0] hist_d [4];
   logic [1:0]  lane;

   always_comb begin
      unique case (slice_sym)
         SYM_M3:  lane = 2'd0;
         SYM_M1:  lane = 2'd1;
         SYM_P1:  lane = 2'd2;
         default: lane = 2'd3;
      endcase
      hist_d = hist_q;
      if (state_q == IDLE && en) begin
         for (int i = 0; i < 4; i++) hist_d[i] = '0;
      end else if (state_q == RUN && sample_in_valid && hist_q[lane] != '1) begin
         hist_d[lane] = hist_q[lane] + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < 4; i++) hist_q[i] <= '0;
      end else begin
         hist_q <= hist_d;
      end
   end

   assign hist_cnt = {hist_q[3], hist_q[2], hist_q[1], hist_q[0]};
`endif

endmodule

// File: tb/tb_rx_pam4_slicer_ber.sv
// Directed bench for rx_pam4_slicer_ber: threshold table plus multi-cycle sequences,
// with a second CNT_W=4 instance sharing stimulus for saturation.
module tb_rx_pam4_slicer_ber;

   logic        clk = 1'b0;
   logic        rstn;
   logic        en;
   logic [7:0]  sample_in;
   logic        sample_in_valid;
   logic [1:0]  ref_sym;
   logic        ref_sym_valid;

   logic [1:0]  sym_out, s_sym_out;
   logic        sym_out_valid, s_sym_out_valid;
   logic [31:0] sym_cnt, sym_err_cnt, bit_err_cnt;
   logic [3:0]  s_sym_cnt, s_sym_err_cnt, s_bit_err_cnt;
   logic        done, ovf, unf, s_done, s_ovf, s_unf;
`ifdef RX_SLICER_HIST_EN
   logic [63:0] hist_cnt, s_hist_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rx_pam4_slicer_ber dut (
      .clk             (clk),
      .rstn            (rstn),
      .en              (en),
      .sample_in       (sample_in),
      .sample_in_valid (sample_in_valid),
      .ref_sym         (ref_sym),
      .ref_sym_valid   (ref_sym_valid),
      .sym_out         (sym_out),
      .sym_out_valid   (sym_out_valid),
      .sym_cnt         (sym_cnt),
      .sym_err_cnt     (sym_err_cnt),
      .bit_err_cnt     (bit_err_cnt),
      .done            (done),
      .ovf             (ovf),
      .unf             (unf)
`ifdef RX_SLICER_HIST_EN
      ,
      .hist_cnt        (hist_cnt)
`endif
   );

   rx_pam4_slicer_ber #(
      .CNT_W (4)
   ) dut_s (
      .clk             (clk),
      .rstn            (rstn),
      .en              (en),
      .sample_in       (sample_in),
      .sample_in_valid (sample_in_valid),
      .ref_sym         (ref_sym),
      .ref_sym_valid   (ref_sym_valid),
      .sym_out         (s_sym_out),
      .sym_out_valid   (s_sym_out_valid),
      .sym_cnt         (s_sym_cnt),
      .sym_err_cnt     (s_sym_err_cnt),
      .bit_err_cnt     (s_bit_err_cnt),
      .done            (s_done),
      .ovf             (s_ovf),
      .unf             (s_unf)
`ifdef RX_SLICER_HIST_EN
      ,
      .hist_cnt        (s_hist_cnt)
`endif
   );

   typedef struct {
      logic [7:0] smp;
      logic [1:0] sym;
   } thr_vec_t;

   thr_vec_t tv [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic sv, input logic [7:0] s, input logic rv,
                       input logic [1:0] r);
      sample_in_valid = sv;
      sample_in       = s;
      ref_sym_valid   = rv;
      ref_sym         = r;
      step();
      sample_in_valid = 1'b0;
      ref_sym_valid   = 1'b0;
   endtask

   function automatic logic [1:0] lvl_sym(input int k);
      case (k % 4)
         0:       return 2'b00;
         1:       return 2'b01;
         2:       return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   function automatic logic [7:0] lvl_smp(input int k);
      case (k % 4)
         0:       return 8'hA0;  // -96
         1:       return 8'hE0;  // -32
         2:       return 8'h20;  // +32
         default: return 8'h60;  // +96
      endcase
   endfunction

   // errs=0: clean rotating levels; errs=1: ref 00 against sample +96 (one bit error).
   task automatic stream(input int n, input bit errs);
      send(1'b0, 8'h00, 1'b1, errs ? 2'b00 : lvl_sym(0));
      for (int i = 0; i < n; i++) begin
         send(1'b1, errs ? 8'h60 : lvl_smp(i), (i < n - 1),
              errs ? 2'b00 : lvl_sym(i + 1));
      end
   endtask

   task automatic restart();
      en = 1'b0;
      step();
      en = 1'b1;
      step();
   endtask

   initial begin
      tv[0] = '{smp: 8'hBF, sym: 2'b00};  // -65
      tv[1] = '{smp: 8'hC0, sym: 2'b01};  // -64
      tv[2] = '{smp: 8'hFF, sym: 2'b01};  // -1
      tv[3] = '{smp: 8'h00, sym: 2'b11};  // 0
      tv[4] = '{smp: 8'h3F, sym: 2'b11};  // 63
      tv[5] = '{smp: 8'h40, sym: 2'b10};  // 64
      tv[6] = '{smp: 8'h80, sym: 2'b00};  // -128
      tv[7] = '{smp: 8'h7F, sym: 2'b10};  // 127

      rstn = 1'b0;
      en = 1'b0;
      sample_in = '0;
      sample_in_valid = 1'b0;
      ref_sym = '0;
      ref_sym_valid = 1'b0;
      step();
      step();
      chk("rst_sym_out", 32'(sym_out), 0);
      chk("rst_sym_vld", 32'(sym_out_valid), 0);
      chk("rst_sym_cnt", sym_cnt, 0);
      chk("rst_err_cnt", sym_err_cnt, 0);
      chk("rst_bit_cnt", bit_err_cnt, 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_ovf", 32'(ovf), 0);
      chk("rst_unf", 32'(unf), 0);
      rstn = 1'b1;
      step();

      // Thresholds, sliced while IDLE
      for (int i = 0; i < 8; i++) begin
         send(1'b1, tv[i].smp, 1'b0, 2'b00);
         chk($sformatf("thr_sym[%0d]", i), 32'(sym_out), 32'(tv[i].sym));
         chk($sformatf("thr_vld[%0d]", i), 32'(sym_out_valid), 1);
      end
      step();
      chk("hold_vld", 32'(sym_out_valid), 0);
      chk("hold_sym", 32'(sym_out), 32'(2'b10));
      chk("idle_sym_cnt", sym_cnt, 0);

      // Clean 1024-symbol window
      restart();
      stream(1024, 1'b0);
      chk("clean_cnt", sym_cnt, 1024);
      chk("clean_done_early", 32'(done), 0);
      step();
      chk("clean_done", 32'(done), 1);
      chk("clean_err", sym_err_cnt, 0);
      chk("clean_bit", bit_err_cnt, 0);
      chk("clean_ovf", 32'(ovf), 0);
      chk("clean_unf", 32'(unf), 0);
      send(1'b1, 8'h60, 1'b1, 2'b00);
      chk("done_slice", 32'(sym_out), 32'(2'b10));
      chk("done_frozen_cnt", sym_cnt, 1024);
      chk("done_frozen_err", sym_err_cnt, 0);
      chk("done_held", 32'(done), 1);
      en = 1'b0;
      step();
      chk("idle_hold_cnt", sym_cnt, 1024);

      // Error injection
      en = 1'b1;
      step();
      chk("start_clr_cnt", sym_cnt, 0);
      chk("start_clr_done", 32'(done), 0);
      send(1'b0, 8'h00, 1'b1, 2'b00);
      send(1'b1, 8'h60, 1'b1, 2'b01);
      chk("inj1_sym", 32'(sym_out), 32'(2'b10));
      chk("inj1_err", sym_err_cnt, 1);
      chk("inj1_bit", bit_err_cnt, 1);
      send(1'b1, 8'h60, 1'b0, 2'b00);
      chk("inj2_err", sym_err_cnt, 2);
      chk("inj2_bit", bit_err_cnt, 3);
      chk("inj2_cnt", sym_cnt, 2);

      // Buffering: fill, push+pop at full, drop, drain, underflow
      restart();
      for (int i = 0; i < 16; i++) send(1'b0, 8'h00, 1'b1, lvl_sym(i));
      chk("fill_ovf", 32'(ovf), 0);
      send(1'b1, lvl_smp(0), 1'b1, lvl_sym(16));
      chk("full_pp_ovf", 32'(ovf), 0);
      chk("full_pp_cnt", sym_cnt, 1);
      send(1'b0, 8'h00, 1'b1, 2'b11);
      chk("drop_ovf", 32'(ovf), 1);
      for (int i = 1; i <= 16; i++) send(1'b1, lvl_smp(i), 1'b0, 2'b00);
      chk("drain_cnt", sym_cnt, 17);
      chk("drain_err", sym_err_cnt, 0);
      chk("drain_unf", 32'(unf), 0);
      send(1'b1, 8'h20, 1'b0, 2'b00);
      chk("unf_set", 32'(unf), 1);
      chk("unf_cnt", sym_cnt, 17);
      chk("unf_vld", 32'(sym_out_valid), 1);

      // Control: en dropped at 500, restart, async reset mid-run
      restart();
      stream(500, 1'b0);
      chk("ctl_cnt500", sym_cnt, 500);
      en = 1'b0;
      step();
      chk("ctl_idle_cnt", sym_cnt, 500);
      send(1'b1, 8'h60, 1'b1, 2'b00);
      chk("ctl_idle_nocnt", sym_cnt, 500);
      chk("ctl_idle_err", sym_err_cnt, 0);
      en = 1'b1;
      step();
      chk("ctl_restart_cnt", sym_cnt, 0);
      stream(5, 1'b1);
      chk("pre_rst_cnt", sym_cnt, 5);
      chk("pre_rst_vld", 32'(sym_out_valid), 1);
      #2;
      rstn = 1'b0;
      en = 1'b0;
      #1;
      chk("arst_cnt", sym_cnt, 0);
      chk("arst_err", sym_err_cnt, 0);
      chk("arst_bit", bit_err_cnt, 0);
      chk("arst_vld", 32'(sym_out_valid), 0);
      chk("arst_sym", 32'(sym_out), 0);
      step();
      rstn = 1'b1;
      step();

      // Saturation: 20 one-bit errors
      en = 1'b1;
      step();
      stream(20, 1'b1);
      chk("sat_wide_err", sym_err_cnt, 20);
      chk("sat_wide_bit", bit_err_cnt, 20);
      chk("sat4_err", 32'(s_sym_err_cnt), 15);
      chk("sat4_bit", 32'(s_bit_err_cnt), 15);
      chk("sat4_cnt", 32'(s_sym_cnt), 15);
      chk("sat4_done", 32'(s_done), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
